// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: three-stage pipelined parallel-prefix adder/subtractor
// with valid/ready handshakes on both sides.
//   S1: per-bit propagate/generate and per-group (G,P) pairs
//   S2: carries into every group from a Kogge-Stone tree over the groups
//   S3: per-group ripple sum plus carry-out and optional flags
// Optional feature macro: PREFIX_ADDER_FLAGS_EN
//   defined   -> out_ovf / out_zero are computed and registered in S3
//   undefined -> out_ovf / out_zero are tied low and no flag logic exists
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = WIDTH / GROUPSIZE;

  // Group generate: carry out of each group assuming a zero carry into it.
  function automatic logic [NG-1:0] group_gen(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] g);
    logic [NG-1:0] gg;
    logic          c;
    gg = '0;
    for (int j = 0; j < NG; j++) begin
      c = 1'b0;
      for (int i = 0; i < GROUPSIZE; i++) begin
        c = g[j*GROUPSIZE+i] | (p[j*GROUPSIZE+i] & c);
      end
      gg[j] = c;
    end
    return gg;
  endfunction

  // Group propagate: every bit of the group propagates.
  function automatic logic [NG-1:0] group_prop(input logic [WIDTH-1:0] p);
    logic [NG-1:0] gp;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*GROUPSIZE +: GROUPSIZE];
    end
    return gp;
  endfunction

  // Kogge-Stone prefix over the groups; returns the carry into each group in
  // [NG-1:0] and the final carry-out in [NG]. The global carry-in is folded in
  // after the tree so the tree itself stays log2(NG) levels deep.
  function automatic logic [NG:0] prefix_carry(input logic [NG-1:0] gg,
                                               input logic [NG-1:0] gp,
                                               input logic          c0);
    logic [NG-1:0] g, p, gn, pn;
    logic [NG:0]   c;
    g = gg;
    p = gp;
    for (int d = 1; d < NG; d = d * 2) begin
      gn = g;
      pn = p;
      for (int j = d; j < NG; j++) begin
        gn[j] = g[j] | (p[j] & g[j-d]);
        pn[j] = p[j] & p[j-d];
      end
      g = gn;
      p = pn;
    end
    c[0] = c0;
    for (int j = 0; j < NG; j++) begin
      c[j+1] = g[j] | (p[j] & c0);
    end
    return c;
  endfunction

  // Short ripple inside each group, seeded by the group carry from the tree.
  function automatic logic [WIDTH-1:0] ripple_sum(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] g,
                                                  input logic [NG-1:0]    cg);
    logic [WIDTH-1:0] s;
    logic             c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % GROUPSIZE) == 0) c = cg[i / GROUPSIZE];
      s[i] = p[i] ^ c;
      c    = g[i] | (p[i] & c);
    end
    return s;
  endfunction

  // Handshake: a stage loads when it is empty or its successor moves on.
  logic s1_vld_q, s2_vld_q, s3_vld_q;
  logic s1_en, s2_en, s3_en;

  assign s3_en     = !s3_vld_q || out_ready;
  assign s2_en     = !s2_vld_q || s3_en;
  assign s1_en     = !s1_vld_q || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s3_vld_q;

  // ---- S0 -> S1 boundary ----
  logic [WIDTH-1:0] bx;
  logic             c0_d;
  logic [WIDTH-1:0] s1_p_d, s1_g_d;
  logic [WIDTH-1:0] s1_p_q, s1_g_q;
  logic [NG-1:0]    s1_gg_q, s1_gp_q;
  logic             s1_c0_q;

  assign bx     = in_sub ? ~in_b : in_b;
  assign c0_d   = in_sub | in_cin;
  assign s1_p_d = in_a ^ bx;
  assign s1_g_d = in_a & bx;

  // S1 capture: bit and group propagate/generate of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_p_q   <= '0;
      s1_g_q   <= '0;
      s1_gg_q  <= '0;
      s1_gp_q  <= '0;
      s1_c0_q  <= 1'b0;
    end else begin
      if (s1_en) s1_vld_q <= in_valid;
      if (s1_en && in_valid) begin
        s1_p_q  <= s1_p_d;
        s1_g_q  <= s1_g_d;
        s1_gg_q <= group_gen(s1_p_d, s1_g_d);
        s1_gp_q <= group_prop(s1_p_d);
        s1_c0_q <= c0_d;
      end
    end
  end

  // ---- S1 -> S2 boundary ----
  logic [NG:0]      s2_carry_d;
  logic [WIDTH-1:0] s2_p_q, s2_g_q;
  logic [NG-1:0]    s2_cg_q;
  logic             s2_cout_q;

  assign s2_carry_d = prefix_carry(s1_gg_q, s1_gp_q, s1_c0_q);

  // S2 capture: group carries from the prefix tree, bit p/g passed along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_p_q    <= '0;
      s2_g_q    <= '0;
      s2_cg_q   <= '0;
      s2_cout_q <= 1'b0;
    end else begin
      if (s2_en) s2_vld_q <= s1_vld_q;
      if (s2_en && s1_vld_q) begin
        s2_p_q    <= s1_p_q;
        s2_g_q    <= s1_g_q;
        s2_cg_q   <= s2_carry_d[NG-1:0];
        s2_cout_q <= s2_carry_d[NG];
      end
    end
  end

  // ---- S2 -> S3 boundary ----
  logic [WIDTH-1:0] s3_sum_d;
  logic [WIDTH-1:0] s3_sum_q;
  logic             s3_cout_q;

  assign s3_sum_d = ripple_sum(s2_p_q, s2_g_q, s2_cg_q);

  // S3 capture: final sum and carry-out, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld_q  <= 1'b0;
      s3_sum_q  <= '0;
      s3_cout_q <= 1'b0;
    end else begin
      if (s3_en) s3_vld_q <= s2_vld_q;
      if (s3_en && s2_vld_q) begin
        s3_sum_q  <= s3_sum_d;
        s3_cout_q <= s2_cout_q;
      end
    end
  end

  assign out_sum  = s3_sum_q;
  assign out_cout = s3_cout_q;

`ifdef PREFIX_ADDER_FLAGS_EN
  // Equal adder-input MSBs show up as p=0 at the MSB, and then g equals that
  // shared MSB, so overflow is "p clear and sum MSB differs from g".
  logic s3_ovf_d, s3_zero_d;
  logic s3_ovf_q, s3_zero_q;

  assign s3_ovf_d  = ~s2_p_q[WIDTH-1] & (s3_sum_d[WIDTH-1] ^ s2_g_q[WIDTH-1]);
  assign s3_zero_d = ~|s3_sum_d;

  // S3 flag capture, same enable as the sum so flags stay paired with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_ovf_q  <= 1'b0;
      s3_zero_q <= 1'b0;
    end else if (s3_en && s2_vld_q) begin
      s3_ovf_q  <= s3_ovf_d;
      s3_zero_q <= s3_zero_d;
    end
  end

  assign out_ovf  = s3_ovf_q;
  assign out_zero = s3_zero_q;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule
